fetch_pc_scheduler: RTL

- Sequencing controller for the instruction fetch stage. Owns the PC and picks the next-PC source each cycle: sequential, jump, predicted branch, misprediction rollback, or load-use hold.
- Keeps a single 2-bit saturating branch predictor and the end-of-program drain counter.
- Sits between the decode feedback (fetched instruction class and immediate) and the execute-stage branch resolution.
- The fetch/decode block becomes a pure memory-read plus decode path addressed by pc_x70.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_pc_scheduler_branch_pred_2b.sv | 30 +++
 rtl/fetch_pc_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC scheduler.
//   state_t  : sequencing FSM states
//   pc_src_t : which source feeds the next PC
//   opcode and predictor constants, and the saturating predictor step
package fetch_pkg;

  typedef enum logic [2:0] {IDLE, RUN, WAIT_RES, DRAIN, DONE} state_t;

  typedef enum logic [2:0] {SEQ, JUMP, BR_PRED, ROLLBACK, HOLD} pc_src_t;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b100011;

  localparam logic [1:0] PRED_SNT = 2'b00;
  localparam logic [1:0] PRED_ST  = 2'b11;

  // One step of a 2-bit saturating counter.
  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == PRED_ST) ? PRED_ST : cur + 2'd1;
    return (cur == PRED_SNT) ? PRED_SNT : cur - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_pc_scheduler_branch_pred_2b.sv
// 2-bit saturating branch predictor.
//   clk, rst_n : clock and async active-low reset
//   update_en  : apply one resolution this cycle
//   taken      : resolved outcome (taken increments, not-taken decrements)
//   state      : current counter value; bit 1 is the prediction
module branch_pred_2b
  import fetch_pkg::*;
#(
  parameter logic [1:0] PRED_INIT = PRED_SNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update_en,
  input  logic       taken,
  output logic [1:0] state
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= PRED_INIT;
    end else if (update_en) begin
      cnt_q <= sat_update(cnt_q, taken);
    end
  end

  assign state = cnt_q;

endmodule

// File: rtl/fetch_pc_scheduler.sv
// Fetch-stage sequencing controller: owns the PC and picks the next-PC
// source each cycle (sequential, jump, predicted branch, rollback, hold).
//   clk_x70, rst_n_x70        : clock, async active-low reset
//   dec_is_beq/j/imm_x70      : decode of the instruction at pc_x70
//   load_use_x70              : hold the instruction at pc_x70 one cycle
//   resolve_valid/taken_x70   : execute-stage resolution of the in-flight BEQ
//   pc_x70, fetch_valid_x70   : fetch address and whether it is a real slot
//   predicted_x70             : prediction for a BEQ at pc_x70
//   flush_x70                 : squash the wrong-path instruction in decode
//   pred_state_x70            : predictor counter
//   finished_x70              : sticky end-of-program flag
module fetch_pc_scheduler
  import fetch_pkg::*;
#(
  parameter int         TOTAL_INSTR  = 14,
  parameter int         PC_W         = 32,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [1:0] PRED_INIT    = 2'b00
) (
  input  logic            clk_x70,
  input  logic            rst_n_x70,
  input  logic            dec_is_beq_x70,
  input  logic            dec_is_j_x70,
  input  logic [15:0]     dec_imm_x70,
  input  logic            load_use_x70,
  input  logic            resolve_valid_x70,
  input  logic            resolve_taken_x70,
  output logic [PC_W-1:0] pc_x70,
  output logic            fetch_valid_x70,
  output logic            predicted_x70,
  output logic            flush_x70,
  output logic [1:0]      pred_state_x70,
  output logic            finished_x70
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [PC_W-1:0]    LAST_PC  = PC_W'((TOTAL_INSTR - 1) * 4);
  localparam logic [PC_W-1:0]    PC_STEP  = PC_W'(4);
  localparam logic [DRAIN_W-1:0] DRAIN_LD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_1  = DRAIN_W'(1);

  state_t            state_q, state_d;
  pc_src_t           src;
  logic [PC_W-1:0]   pc_q, pc_d, rollback_q, rollback_d;
  logic [PC_W-1:0]   pc_nxt, seq_pc, target, offset;
  logic              fv_q, fv_d, flush_q, flush_d;
  logic              pred_taken_q, pred_taken_d;
  logic              past_end_q, past_end_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic              outstanding, out_nxt, res_ok, mispredict, go_drain;
  logic              pred_upd;
  logic [1:0]        pred_state;

  branch_pred_2b #(.PRED_INIT(PRED_INIT)) u_pred (
    .clk       (clk_x70),
    .rst_n     (rst_n_x70),
    .update_en (pred_upd),
    .taken     (resolve_taken_x70),
    .state     (pred_state)
  );

  // Two's-complement add gives the signed, PC_W-truncated result directly.
  assign offset      = {{(PC_W-18){dec_imm_x70[15]}}, dec_imm_x70, 2'b00};
  assign seq_pc      = pc_q + PC_STEP;
  assign target      = pc_q + offset + PC_STEP;
  // A branch is in flight exactly while in WAIT_RES.
  assign outstanding = (state_q == WAIT_RES);
  assign res_ok      = resolve_valid_x70 & outstanding;
  assign mispredict  = res_ok & (resolve_taken_x70 != pred_taken_q);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rollback_d   = rollback_q;
    fv_d         = fv_q;
    flush_d      = 1'b0;
    pred_taken_d = pred_taken_q;
    past_end_d   = past_end_q;
    drain_d      = drain_q;
    src          = HOLD;
    pc_nxt       = pc_q;
    out_nxt      = outstanding;
    pred_upd     = 1'b0;
    go_drain     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = RUN;
        fv_d    = 1'b1;
      end

      RUN, WAIT_RES: begin
        pred_upd = res_ok;
        if (res_ok) out_nxt = 1'b0;

        // past_end_q: the final branch pointed past the program; the held
        // PC is that branch, so decode must not reissue it.
        if (mispredict)                          src = ROLLBACK;
        else if (past_end_q || load_use_x70)     src = HOLD;
        else if (dec_is_j_x70)                   src = JUMP;
        else if (dec_is_beq_x70 && !outstanding) src = BR_PRED;
        else if (dec_is_beq_x70)                 src = HOLD;
        else                                     src = SEQ;

        case (src)
          ROLLBACK: begin
            pc_nxt  = rollback_q;
            flush_d = 1'b1;
          end
          JUMP: pc_nxt = target;
          BR_PRED: begin
            out_nxt      = 1'b1;
            pred_taken_d = pred_state[1];
            pc_nxt       = pred_state[1] ? target : seq_pc;
            rollback_d   = pred_state[1] ? seq_pc : target;
          end
          SEQ:     pc_nxt = seq_pc;
          default: pc_nxt = pc_q;
        endcase

        if (src == HOLD) begin
          fv_d = 1'b0;
          if (past_end_q && !out_nxt) go_drain = 1'b1;
          else                        state_d = out_nxt ? WAIT_RES : RUN;
        end else if (pc_nxt > LAST_PC) begin
          fv_d = 1'b0;
          if (out_nxt) begin
            state_d    = WAIT_RES;
            past_end_d = 1'b1;
          end else begin
            go_drain = 1'b1;
          end
        end else begin
          pc_d       = pc_nxt;
          fv_d       = 1'b1;
          past_end_d = 1'b0;
          state_d    = out_nxt ? WAIT_RES : RUN;
        end

        if (go_drain) begin
          state_d    = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          drain_d    = DRAIN_LD;
          past_end_d = 1'b0;
        end
      end

      DRAIN: begin
        fv_d = 1'b0;
        if (drain_q <= DRAIN_1) begin
          state_d = DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRAIN_1;
        end
      end

      default: fv_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      rollback_q   <= '0;
      fv_q         <= 1'b0;
      flush_q      <= 1'b0;
      pred_taken_q <= 1'b0;
      past_end_q   <= 1'b0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rollback_q   <= rollback_d;
      fv_q         <= fv_d;
      flush_q      <= flush_d;
      pred_taken_q <= pred_taken_d;
      past_end_q   <= past_end_d;
      drain_q      <= drain_d;
    end
  end

  assign pc_x70          = pc_q;
  assign fetch_valid_x70 = fv_q;
  assign flush_x70       = flush_q;
  assign predicted_x70   = pred_state[1];
  assign pred_state_x70  = pred_state;
  assign finished_x70    = (state_q == DONE);

endmodule
